// File: rtl/pipe_hazard_ctrl.sv
// Hazard, flush and WFI sleep/wake control for the IF/ID and ID/EX registers.
// Resolves load-use, memory waits, taken branches and interrupt entry.
module pipe_hazard_ctrl #(
  parameter int WFI_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           ID_rs1,
  input  logic [4:0]           ID_rs2,
  input  logic [4:0]           EX_rd,
  input  logic                 EX_MemRead,
  input  logic                 branch_taken_EX,
  input  logic                 mem_stall,
  input  logic                 WFI_ID,
  input  logic                 ext_irq,
  input  logic                 csr_MIE,
  input  logic                 csr_MEIE,
  output logic                 stall,
  output logic                 pc_ifid_stall,
  output logic                 HazardMuxControl,
  output logic                 flush_IFID,
  output logic                 WFI,
  output logic                 interrupt_pulse,
  output logic                 irq_taken,
  output logic [WFI_CNT_W-1:0] wfi_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLEEP = 2'd1,
    TAKE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic irq_en;
  logic wake;
  logic irq_en_d;
  logic irq_pend;
  logic load_use;

  assign irq_en = ext_irq & csr_MIE & csr_MEIE;
  // Wake-up ignores the global enable so WFI can resume without a trap.
  assign wake   = ext_irq & csr_MEIE;

  assign load_use = EX_MemRead
                  & (EX_rd != 5'd0)
                  & ((EX_rd == ID_rs1) | (EX_rd == ID_rs2));

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (irq_pend && !mem_stall)
          state_nxt = TAKE;
        else if (WFI_ID && !mem_stall && !branch_taken_EX)
          state_nxt = SLEEP;
      end
      SLEEP: begin
        if (wake) state_nxt = irq_en ? TAKE : RUN;
      end
      TAKE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    WFI             = (state == SLEEP);
    interrupt_pulse = (state == TAKE);
    irq_taken       = (state == TAKE);
  end

  // Pending is edge-armed and dropped if the request vanishes before entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_d <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      irq_en_d <= irq_en;
      if (interrupt_pulse || !irq_en)
        irq_pend <= 1'b0;
      else if (!irq_en_d)
        irq_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      wfi_cycles <= '0;
    else if (state == SLEEP && wfi_cycles != '1)
      wfi_cycles <= wfi_cycles + 1'b1;
  end

  always_comb begin
    stall            = 1'b0;
    pc_ifid_stall    = 1'b0;
    HazardMuxControl = 1'b0;
    flush_IFID       = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        stall         = 1'b1;
        pc_ifid_stall = 1'b1;
      end else if (state == TAKE) begin
        flush_IFID       = 1'b1;
        HazardMuxControl = 1'b1;
      end else if (branch_taken_EX) begin
        flush_IFID       = 1'b1;
        HazardMuxControl = 1'b1;
      end else if (load_use) begin
        pc_ifid_stall    = 1'b1;
        HazardMuxControl = 1'b1;
      end else if (state == SLEEP) begin
        pc_ifid_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl.
// Output vector order: stall, pc_ifid_stall, HMC, flush, WFI, pulse, taken.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        EX_MemRead, branch_taken_EX, mem_stall;
  logic        WFI_ID, ext_irq, csr_MIE, csr_MEIE;
  logic        stall, pc_ifid_stall, HazardMuxControl, flush_IFID;
  logic        WFI, interrupt_pulse, irq_taken;
  logic [31:0] wfi_cycles;

  typedef struct packed {
    logic [6:0]  o;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [6:0] ZEROV  = 7'b0000000;
  localparam logic [6:0] STALLV = 7'b1100000;
  localparam logic [6:0] LUV    = 7'b0110000;
  localparam logic [6:0] FLUSHV = 7'b0011000;
  localparam logic [6:0] TAKEV  = 7'b0011011;
  localparam logic [6:0] SLEEPV = 7'b0100100;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  pipe_hazard_ctrl #(.WFI_CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .ID_rs1           (ID_rs1),
    .ID_rs2           (ID_rs2),
    .EX_rd            (EX_rd),
    .EX_MemRead       (EX_MemRead),
    .branch_taken_EX  (branch_taken_EX),
    .mem_stall        (mem_stall),
    .WFI_ID           (WFI_ID),
    .ext_irq          (ext_irq),
    .csr_MIE          (csr_MIE),
    .csr_MEIE         (csr_MEIE),
    .stall            (stall),
    .pc_ifid_stall    (pc_ifid_stall),
    .HazardMuxControl (HazardMuxControl),
    .flush_IFID       (flush_IFID),
    .WFI              (WFI),
    .interrupt_pulse  (interrupt_pulse),
    .irq_taken        (irq_taken),
    .wfi_cycles       (wfi_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {stall, pc_ifid_stall, HazardMuxControl, flush_IFID,
            WFI, interrupt_pulse, irq_taken};
  endfunction

  task automatic clear_inputs();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; EX_rd = 5'd0;
    EX_MemRead = 1'b0; branch_taken_EX = 1'b0; mem_stall = 1'b0;
    WFI_ID = 1'b0; ext_irq = 1'b0; csr_MIE = 1'b1; csr_MEIE = 1'b1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 after reset release.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t ex;
    rst = 1'b1;
    clear_inputs();
    mem_stall = 1'b1; branch_taken_EX = 1'b1;
    EX_MemRead = 1'b1; EX_rd = 5'd3; ID_rs1 = 5'd3;
    ext_irq = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      sb.push_back({ZEROV, 32'd0});
      @(negedge clk);
      ex = sb.pop_front();
      n_chk++;
      if ({outs(), wfi_cycles} !== ex) begin
        n_fail++;
        $display("FAIL reset c=%0d got %b/%0d exp %b/%0d",
                 c, outs(), wfi_cycles, ex.o, ex.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    exp_t ex;
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      e = ZEROV;
      case (i)
        0: begin EX_MemRead = 1; EX_rd = 5; ID_rs2 = 5; e = LUV; end
        1: begin EX_MemRead = 1; EX_rd = 0; end
        2: begin EX_MemRead = 1; EX_rd = 7; ID_rs1 = 7; e = LUV; end
        3: begin EX_MemRead = 0; EX_rd = 7; ID_rs1 = 7; end
        4: begin EX_MemRead = 1; EX_rd = 7; ID_rs1 = 3; ID_rs2 = 4; end
        5: begin
          EX_MemRead = 1; EX_rd = 9; ID_rs1 = 9;
          branch_taken_EX = 1; e = FLUSHV;
        end
        6: begin
          EX_MemRead = 1; EX_rd = 9; ID_rs2 = 9;
          mem_stall = 1; e = STALLV;
        end
        default: begin EX_MemRead = 1; EX_rd = 31; ID_rs2 = 31; e = LUV; end
      endcase
      sb.push_back({e, 32'd0});
      @(negedge clk);
      ex = sb.pop_front();
      n_chk++;
      if ({outs(), wfi_cycles} !== ex) begin
        n_fail++;
        $display("FAIL load_use i=%0d got %b/%0d exp %b/%0d",
                 i, outs(), wfi_cycles, ex.o, ex.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem_stall_branch();
    exp_t ex;
    logic [6:0] e;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      mem_stall       = (c < 3);
      branch_taken_EX = (c < 4);
      e = (c < 3) ? STALLV : (c == 3) ? FLUSHV : ZEROV;
      sb.push_back({e, 32'd0});
      @(negedge clk);
      ex = sb.pop_front();
      n_chk++;
      if ({outs(), wfi_cycles} !== ex) begin
        n_fail++;
        $display("FAIL stall_branch c=%0d got %b/%0d exp %b/%0d",
                 c, outs(), wfi_cycles, ex.o, ex.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_interrupt(input bit delayed);
    exp_t ex;
    logic [6:0] e;
    int pulse_c;
    pulse_c = delayed ? 14 : 12;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      ext_irq   = (c >= 10);
      mem_stall = delayed && (c == 11 || c == 12);
      e = mem_stall ? STALLV : (c == pulse_c) ? TAKEV : ZEROV;
      sb.push_back({e, 32'd0});
      @(negedge clk);
      ex = sb.pop_front();
      n_chk++;
      if ({outs(), wfi_cycles} !== ex) begin
        n_fail++;
        $display("FAIL irq d=%0d c=%0d got %b/%0d exp %b/%0d",
                 delayed, c, outs(), wfi_cycles, ex.o, ex.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wfi(input bit trap);
    exp_t ex;
    logic [6:0] e;
    logic [31:0] ec;
    do_reset();
    csr_MIE = trap;
    for (int c = 0; c < 25; c++) begin
      WFI_ID  = (c == 5);
      ext_irq = (c >= 20);
      if (c >= 6 && c <= 20)    e = SLEEPV;
      else if (trap && c == 21) e = TAKEV;
      else                      e = ZEROV;
      ec = (c <= 6) ? 32'd0 : (c >= 21) ? 32'd15 : 32'(c - 6);
      sb.push_back({e, ec});
      @(negedge clk);
      ex = sb.pop_front();
      n_chk++;
      if ({outs(), wfi_cycles} !== ex) begin
        n_fail++;
        $display("FAIL wfi t=%0d c=%0d got %b/%0d exp %b/%0d",
                 trap, c, outs(), wfi_cycles, ex.o, ex.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_in_sleep();
    exp_t ex;
    logic [6:0] e;
    logic [31:0] ec;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      WFI_ID    = (c == 2);
      rst       = (c == 8);
      mem_stall = (c == 8);
      if (c >= 3 && c <= 7)  begin e = SLEEPV;    ec = 32'(c - 3); end
      else if (c == 8)       begin e = 7'b0000100; ec = 32'd5; end
      else                   begin e = ZEROV;     ec = 32'd0; end
      sb.push_back({e, ec});
      @(negedge clk);
      ex = sb.pop_front();
      n_chk++;
      if ({outs(), wfi_cycles} !== ex) begin
        n_fail++;
        $display("FAIL rst_sleep c=%0d got %b/%0d exp %b/%0d",
                 c, outs(), wfi_cycles, ex.o, ex.cnt);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t ex;
    logic [6:0] e;
    do_reset();
    for (int c = 0; c < 29; c++) begin
      ext_irq = (c >= 2 && c <= 5) || (c >= 8 && c <= 10)
             || (c == 14) || (c >= 20);
      mem_stall       = (c == 15);
      WFI_ID          = (c == 21) || (c == 26);
      branch_taken_EX = (c == 26);
      if (c == 4 || c == 10 || c == 22) e = TAKEV;
      else if (c == 15)                 e = STALLV;
      else if (c == 26)                 e = FLUSHV;
      else                              e = ZEROV;
      sb.push_back({e, 32'd0});
      @(negedge clk);
      ex = sb.pop_front();
      n_chk++;
      if ({outs(), wfi_cycles} !== ex) begin
        n_fail++;
        $display("FAIL b2b c=%0d got %b/%0d exp %b/%0d",
                 c, outs(), wfi_cycles, ex.o, ex.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_stall_branch();
    test_interrupt(1'b0);
    test_interrupt(1'b1);
    test_wfi(1'b1);
    test_wfi(1'b0);
    test_reset_in_sleep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control block that generates the hold, bubble, flush and sleep/wake signals consumed by the IF/ID and ID/EX pipeline registers. It resolves four conditions: load-use hazards, memory wait states, taken branches/jumps, and WFI sleep with external-interrupt wake-up. It sits beside the decoder and drives the `stall`, `HazardMuxControl`, `WFI` and `interrupt_pulse` inputs of the pipeline registers.

## Interface
- `WFI_CNT_W`, default 32: width of the sleep-cycle counter.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ID_rs1`, `ID_rs2` in 5 each: source registers of the instruction in ID.
- `EX_rd` in 5: destination register of the instruction in EX.
- `EX_MemRead` in 1: the instruction in EX is a load.
- `branch_taken_EX` in 1: a branch or jump in EX redirects the PC.
- `mem_stall` in 1: IM or DM wait state pending.
- `WFI_ID` in 1: the decoded instruction in ID is WFI.
- `ext_irq` in 1: external interrupt line, level, synchronous to `clk`.
- `csr_MIE` in 1: mstatus.MIE.
- `csr_MEIE` in 1: mie.MEIE.
- `stall` out 1: holds the PC, IF/ID and ID/EX.
- `pc_ifid_stall` out 1: holds the PC and IF/ID only.
- `HazardMuxControl` out 1: zeroes the ID control word, inserting a bubble into ID/EX.
- `flush_IFID` out 1: replaces IF/ID with a NOP.
- `WFI` out 1: core is sleeping.
- `interrupt_pulse` out 1: one-cycle interrupt-take strobe.
- `irq_taken` out 1: same cycle as `interrupt_pulse`; tells the CSR file to save mepc and redirect to mtvec.
- `wfi_cycles` out `WFI_CNT_W`: saturating count of cycles spent in SLEEP.

## Operation
- Definitions:
  - `irq_en = ext_irq & csr_MIE & csr_MEIE`
  - `wake = ext_irq & csr_MEIE`. Wake ignores MIE.
- `irq_pend` register:
  - Set on a rising edge of `irq_en` (compared with registered `irq_en_d`).
  - Cleared when `interrupt_pulse` fires, or when `irq_en` drops before the interrupt is taken.
- State machine, states RUN, SLEEP, TAKE:
  - RUN → TAKE when `irq_pend & !mem_stall`.
  - RUN → SLEEP when `WFI_ID & !irq_pend & !mem_stall & !branch_taken_EX`.
  - SLEEP → TAKE when `wake & irq_en`.
  - SLEEP → RUN when `wake & !irq_en`. Execution resumes at the instruction after WFI; no trap.
  - TAKE → RUN unconditionally after 1 cycle.
- Registered outputs (values reflect the current state):
  - `WFI` = 1 in SLEEP.
  - `interrupt_pulse` = `irq_taken` = 1 in TAKE.
- Combinational outputs, evaluated in priority order:
  1. `mem_stall`: `stall=1`, `pc_ifid_stall=1`; all other combinational outputs 0.
  2. TAKE: `flush_IFID=1`, `HazardMuxControl=1`.
  3. `branch_taken_EX`: `flush_IFID=1`, `HazardMuxControl=1`.
  4. Load-use, when `EX_MemRead & EX_rd!=0 & (EX_rd==ID_rs1 | EX_rd==ID_rs2)`: `pc_ifid_stall=1`, `HazardMuxControl=1`, `stall=0`.
  5. SLEEP: `pc_ifid_stall=1`.
- `wfi_cycles`:
  - Increments by 1 each cycle in SLEEP.
  - Saturates at all-ones.
  - Cleared only by reset.

## Timing
- Reset values:
  - State RUN.
  - `irq_pend=0`, `irq_en_d=0`.
  - `WFI=0`, `interrupt_pulse=0`, `irq_taken=0`, `wfi_cycles=0`.
  - All combinational outputs evaluate to 0 while `rst=1`.
- Combinational hazard outputs have 0-cycle latency from their inputs.
- Interrupt latency:
  - Edge of `irq_en` in cycle N → `irq_pend=1` at N+1.
  - `interrupt_pulse=1` at N+2 if `mem_stall` is low in cycle N+1.
  - Each `mem_stall` cycle delays the pulse by one cycle.
- Wake from SLEEP: `wake` in cycle N → `WFI=0` at N+1.
- `interrupt_pulse` is exactly one cycle wide. A held `ext_irq` produces no second pulse until `irq_en` falls and rises again.
- Simultaneous events:
  - `irq_pend` and `WFI_ID` together: the interrupt wins; no SLEEP entry.
  - `branch_taken_EX` and `WFI_ID` together: the WFI is flushed, so no SLEEP.
- `rst` asserted in SLEEP or TAKE returns to RUN next cycle, with no pulse emitted.

## Test plan
- Load-use: `EX_MemRead=1`, `EX_rd=5`, `ID_rs2=5` → `pc_ifid_stall=1`, `HazardMuxControl=1`, `stall=0`. Repeat with `EX_rd=0` → all outputs 0.
- `mem_stall=1` for 3 cycles with `branch_taken_EX=1` → `stall=1`, `flush_IFID=0` for those 3 cycles; flush appears on the first cycle `mem_stall=0`.
- Interrupt:
  - MIE=MEIE=1, `ext_irq` rises at cycle 10 and is held → `interrupt_pulse=1` only at cycle 12, with `flush_IFID=1` that cycle.
  - Same with `mem_stall=1` in cycles 11-12 → pulse at cycle 14.
- WFI wake with trap: `WFI_ID=1` at cycle 5 → `WFI=1` from cycle 6. `ext_irq=1` at cycle 20 → TAKE at 21 (`interrupt_pulse=1`, `WFI=0`), RUN at 22, `wfi_cycles=15`.
- WFI wake without trap: as above with MIE=0 → `WFI=0` at 21, no pulse, state RUN.
- Reset during SLEEP at cycle 8 → cycle 9: `WFI=0`, `wfi_cycles=0`, no pulse.
